// File: rtl/iob_eth_tx.sv
// MII transmit engine: preamble/SFD, buffered payload with optional zero padding,
// CRC-32 FCS and an enforced inter-frame gap, all in the TX clock domain.
module iob_eth_tx #(
    parameter int BUFFER_W   = 11,
    parameter int PAD_EN     = 1,
    parameter int MIN_FRAME  = 60,
    parameter int IFG_CYCLES = 24
) (
    input  logic                tx_clk_i,
    input  logic                rst_i,
    input  logic                send_i,
    input  logic [BUFFER_W-1:0] tx_nbytes_i,
    output logic                ready_o,
    output logic [BUFFER_W-1:0] addr_o,
    input  logic [7:0]          data_i,
    output logic                tx_en_o,
    output logic [3:0]          tx_data_o
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PREAMBLE = 3'd1;
    localparam logic [2:0] ST_DATA     = 3'd2;
    localparam logic [2:0] ST_PAD      = 3'd3;
    localparam logic [2:0] ST_FCS      = 3'd4;
    localparam logic [2:0] ST_IFG      = 3'd5;

    localparam int          IFG_W    = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [31:0] CRC_POLY = 32'hEDB88320;

    logic [2:0]          state;
    logic [BUFFER_W-1:0] len_r;
    logic [BUFFER_W-1:0] byte_cnt;
    logic [3:0]          nib_cnt;
    logic [IFG_W-1:0]    ifg_cnt;
    logic                hi_nib;
    logic [3:0]          hi_r;
    logic [31:0]         crc;
    logic [31:0]         fcs;
    logic                pad_needed;
    logic                last_data;
    logic                last_pad;
    logic                last_ifg;

    // Reflected CRC-32, one byte per call, LSB of the byte first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int unsigned i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ CRC_POLY;
            else             r = r >> 1;
        end
        return r;
    endfunction

    always_comb begin
        pad_needed = (PAD_EN != 0) && (32'(len_r) < 32'(MIN_FRAME));
        last_data  = (byte_cnt == len_r - BUFFER_W'(1));
        last_pad   = (32'(byte_cnt) == 32'(MIN_FRAME - 1));
        last_ifg   = (ifg_cnt == IFG_W'(IFG_CYCLES - 1));
        fcs        = ~crc;
    end

    assign ready_o = (state == ST_IDLE);

    // Outputs lag the state by one edge: each branch registers the nibble for the next cycle.
    // The low nibble comes straight from data_i; the high nibble is held for the following cycle.
    always_ff @(posedge tx_clk_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            len_r     <= '0;
            byte_cnt  <= '0;
            nib_cnt   <= '0;
            ifg_cnt   <= '0;
            hi_nib    <= 1'b0;
            hi_r      <= '0;
            crc       <= '1;
            addr_o    <= '0;
            tx_en_o   <= 1'b0;
            tx_data_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    tx_en_o   <= 1'b0;
                    tx_data_o <= '0;
                    addr_o    <= '0;
                    if (send_i) begin
                        len_r    <= tx_nbytes_i;
                        byte_cnt <= '0;
                        nib_cnt  <= '0;
                        hi_nib   <= 1'b0;
                        crc      <= '1;
                        state    <= ST_PREAMBLE;
                    end
                end
                ST_PREAMBLE: begin
                    tx_en_o <= 1'b1;
                    if (nib_cnt == 4'd15) begin
                        tx_data_o <= 4'hD;
                        nib_cnt   <= '0;
                        if (len_r != '0)     state <= ST_DATA;
                        else if (pad_needed) state <= ST_PAD;
                        else                 state <= ST_FCS;
                    end else begin
                        tx_data_o <= 4'h5;
                        nib_cnt   <= nib_cnt + 4'd1;
                    end
                end
                ST_DATA: begin
                    tx_en_o <= 1'b1;
                    if (!hi_nib) begin
                        tx_data_o <= data_i[3:0];
                        hi_r      <= data_i[7:4];
                        crc       <= crc_byte(crc, data_i);
                        addr_o    <= addr_o + BUFFER_W'(1);
                        hi_nib    <= 1'b1;
                    end else begin
                        tx_data_o <= hi_r;
                        hi_nib    <= 1'b0;
                        byte_cnt  <= byte_cnt + BUFFER_W'(1);
                        if (last_data) state <= pad_needed ? ST_PAD : ST_FCS;
                    end
                end
                ST_PAD: begin
                    tx_en_o   <= 1'b1;
                    tx_data_o <= '0;
                    if (!hi_nib) begin
                        crc    <= crc_byte(crc, 8'h00);
                        hi_nib <= 1'b1;
                    end else begin
                        hi_nib   <= 1'b0;
                        byte_cnt <= byte_cnt + BUFFER_W'(1);
                        if (last_pad) state <= ST_FCS;
                    end
                end
                ST_FCS: begin
                    tx_en_o   <= 1'b1;
                    tx_data_o <= fcs[{nib_cnt[2:0], 2'b00} +: 4];
                    if (nib_cnt == 4'd7) begin
                        nib_cnt <= '0;
                        ifg_cnt <= '0;
                        state   <= ST_IFG;
                    end else begin
                        nib_cnt <= nib_cnt + 4'd1;
                    end
                end
                ST_IFG: begin
                    tx_en_o   <= 1'b0;
                    tx_data_o <= '0;
                    if (last_ifg) begin
                        addr_o <= '0;
                        state  <= ST_IDLE;
                    end else begin
                        ifg_cnt <= ifg_cnt + IFG_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
